mult_unit: RTL
==============

MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 32, the operand width in bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 sign  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with start.
REQ-006 A  input  WIDTH  multiplicand; sampled with start.
REQ-007 B  input  WIDTH  multiplier; sampled with start.
REQ-008 mthi  input  1  write wdata into HI.
REQ-009 mtlo  input  1  write wdata into LO.
REQ-010 wdata  input  WIDTH  data for mthi/mtlo.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when HI/LO receive a product.
REQ-013 hi  output  WIDTH  HI register.
REQ-014 lo  output  WIDTH  LO register.
REQ-015 mult_result  output  2*WIDTH  {hi, lo}.

Function
REQ-016 States SHALL be IDLE, RUN and FIX; busy SHALL be high in RUN and FIX only.
REQ-017 In IDLE, start=1 SHALL latch the operand magnitudes, the result sign and the mode, clear the 2*WIDTH accumulator and the cycle counter, and move to RUN.
REQ-018 Operand magnitudes SHALL be the two's-complement absolute values when sign=1, and the raw values when sign=0.
REQ-019 The result sign SHALL be A[WIDTH-1] XOR B[WIDTH-1] when sign=1, and 0 otherwise.
REQ-020 In RUN, each cycle SHALL examine one multiplier bit, LSB first; if the bit is 1, it SHALL add the multiplicand shifted by the counter value; the counter SHALL then increment.
REQ-021 After exactly WIDTH RUN cycles, the state SHALL move to FIX.
REQ-022 In FIX, HI/LO SHALL load the accumulator, negated across the full 2*WIDTH bits if the result sign is 1.
REQ-023 In FIX, done SHALL pulse high and the state SHALL return to IDLE.
REQ-024 Latency: start accepted at edge N -> done high and hi/lo valid in the cycle after edge N+WIDTH+1 (34 cycles for WIDTH=32).
REQ-025 start SHALL be ignored while busy; the operation in progress and its operands SHALL be unaffected.
REQ-026 Operand changes on A/B/sign after the accept edge SHALL NOT affect the result.
REQ-027 In IDLE, mthi/mtlo SHALL write wdata into HI/LO in one cycle; both asserted together SHALL write both registers.
REQ-028 mthi/mtlo SHALL be ignored while busy.
REQ-029 In IDLE, if start and mthi/mtlo are asserted in the same cycle, start SHALL win and the write SHALL be dropped.
REQ-030 hi/lo SHALL hold their value between writes; a new operation SHALL NOT disturb hi/lo until its FIX cycle.
REQ-031 start asserted in the IDLE cycle immediately after a FIX cycle SHALL be accepted, giving back-to-back operations with one idle cycle between them.
REQ-032 Signed corner case: -2^(WIDTH-1) * -2^(WIDTH-1) SHALL yield +2^(2*WIDTH-2) without overflow. The magnitude 2^(WIDTH-1) SHALL be held in a WIDTH-bit unsigned register.
REQ-033 done SHALL never be high for more than one consecutive cycle.

Reset
REQ-034 When reset=1 at a clock edge, the state SHALL become IDLE and hi, lo, busy, done, the accumulator and the counter SHALL become 0.
REQ-035 reset SHALL take priority over start, mthi and mtlo.
REQ-036 reset asserted mid-operation SHALL abort the operation with no done pulse and leave hi/lo = 0.

Verification
REQ-037 Unsigned: sign=0, A=0xFFFFFFFF, B=0xFFFFFFFF, start -> 34 cycles later done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 Signed: sign=1, A=0xFFFFFFFD (-3), B=0x00000007, start -> done; hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); repeat with A=B=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-039 Busy protection: start a multiply of 5*6, then pulse start with new operands and pulse mthi at cycle 10 -> single done, hi=0, lo=30, busy stays high for exactly 33 cycles.
REQ-040 Moves: in IDLE, mthi wdata=0x12345678, then mtlo wdata=0x9ABCDEF0 -> hi/lo updated one cycle later, mult_result=0x123456789ABCDEF0, done stays 0.
REQ-041 Reset mid-operation: start, assert reset at cycle 15 -> next cycle busy=0, hi=lo=0, no done pulse; a fresh start of 2*3 -> lo=6.
REQ-042 Back-to-back: start 7*8, then start 9*9 in the cycle after done -> lo=56 then lo=81, two done pulses 35 cycles apart.

Source files
------------

// File: rtl/mult_unit.sv
// Sequential shift-and-add multiplier with HI/LO result registers.
// Produces one multiplier bit per cycle, then applies the result sign in
// a final FIX cycle; mthi/mtlo give direct write access to HI/LO when idle.
module mult_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 sign,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 mthi,
   input  logic                 mtlo,
   input  logic [WIDTH-1:0]     wdata,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     hi,
   output logic [WIDTH-1:0]     lo,
   output logic [2*WIDTH-1:0]   mult_result
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic                 neg_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic                 done_q;

   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [2*WIDTH-1:0]   addend;
   logic [2*WIDTH-1:0]   result;
   logic                 last_run;

   // Operand magnitudes, shifted multiplicand and signed final result
   always_comb begin
      mag_a    = (sign && A[WIDTH-1]) ? -A : A;
      mag_b    = (sign && B[WIDTH-1]) ? -B : B;
      addend   = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
      result   = neg_q ? -acc_q : acc_q;
      last_run = (cnt_q == CW'(WIDTH - 1));
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_run) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand capture, accumulation, HI/LO writes and done pulse.
   // The multiplier is shifted right so its LSB is always the bit under
   // examination; the counter supplies the multiplicand shift amount.
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q  <= mag_a;
                  mplier_q <= mag_b;
                  neg_q    <= sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                  acc_q    <= '0;
                  cnt_q    <= '0;
               end else begin
                  if (mthi) hi_q <= wdata;
                  if (mtlo) lo_q <= wdata;
               end
            end
            RUN: begin
               if (mplier_q[0]) acc_q <= acc_q + addend;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
            end
            FIX: begin
               {hi_q, lo_q} <= result;
               done_q       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign mult_result = {hi_q, lo_q};

endmodule
